// File: rtl/pixel_pack_writer.sv
// Packs 24-bit pixel words into 16-bit halfwords for the output frame memory.
// Pixel pair A,B is written as A[15:0], {B[7:0],A[23:16]}, B[23:8] at consecutive addresses.
module pixel_pack_writer #(
    parameter int unsigned ADDR_W = 18,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [CNT_W-1:0]  num_pixels,
    input  logic              in_valid,
    input  logic [23:0]       in_data,
    output logic              in_ready,
    output logic              w_en,
    output logic [ADDR_W-1:0] w_addr,
    output logic [15:0]       w_data,
    output logic              busy,
    output logic              done
);

    typedef enum logic [2:0] {
        StIdle,
        StP0,
        StP1,
        StP2,
        StFlush,
        StDone
    } state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [CNT_W-1:0]  remaining_q, remaining_d;
    logic [7:0]        res8_q, res8_d;
    logic [15:0]       res16_q, res16_d;
    logic              w_en_q, w_en_d;
    logic [ADDR_W-1:0] w_addr_q, w_addr_d;
    logic [15:0]       w_data_q, w_data_d;
    logic              done_q, done_d;
    logic              beat;

    assign in_ready = (state_q == StP0) || (state_q == StP1);
    assign beat     = in_valid & in_ready;
    // Busy covers the cycle the registered done pulse is visible, so a new start
    // cannot be accepted before the previous frame has been reported complete.
    assign busy     = (state_q != StIdle) | done_q;

    assign w_en   = w_en_q;
    assign w_addr = w_addr_q;
    assign w_data = w_data_q;
    assign done   = done_q;

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        remaining_d = remaining_q;
        res8_d      = res8_q;
        res16_d     = res16_q;
        w_en_d      = 1'b0;
        w_addr_d    = w_addr_q;
        w_data_d    = w_data_q;
        done_d      = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (start && !done_q) begin
                    addr_d      = base_addr;
                    remaining_d = num_pixels;
                    state_d     = (num_pixels == '0) ? StDone : StP0;
                end
            end
            StP0: begin
                if (beat) begin
                    w_en_d      = 1'b1;
                    w_addr_d    = addr_q;
                    w_data_d    = in_data[15:0];
                    addr_d      = addr_q + ADDR_W'(1);
                    res8_d      = in_data[23:16];
                    remaining_d = remaining_q - CNT_W'(1);
                    state_d     = (remaining_q > CNT_W'(1)) ? StP1 : StFlush;
                end
            end
            StP1: begin
                if (beat) begin
                    w_en_d      = 1'b1;
                    w_addr_d    = addr_q;
                    w_data_d    = {in_data[7:0], res8_q};
                    addr_d      = addr_q + ADDR_W'(1);
                    res16_d     = in_data[23:8];
                    remaining_d = remaining_q - CNT_W'(1);
                    state_d     = StP2;
                end
            end
            StP2: begin
                w_en_d   = 1'b1;
                w_addr_d = addr_q;
                w_data_d = res16_q;
                addr_d   = addr_q + ADDR_W'(1);
                state_d  = (remaining_q != '0) ? StP0 : StDone;
            end
            StFlush: begin
                w_en_d   = 1'b1;
                w_addr_d = addr_q;
                w_data_d = {8'h00, res8_q};
                addr_d   = addr_q + ADDR_W'(1);
                state_d  = StDone;
            end
            StDone: begin
                done_d  = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            addr_q      <= '0;
            remaining_q <= '0;
            res8_q      <= '0;
            res16_q     <= '0;
            w_en_q      <= 1'b0;
            w_addr_q    <= '0;
            w_data_q    <= '0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            remaining_q <= remaining_d;
            res8_q      <= res8_d;
            res16_q     <= res16_d;
            w_en_q      <= w_en_d;
            w_addr_q    <= w_addr_d;
            w_data_q    <= w_data_d;
            done_q      <= done_d;
        end
    end

endmodule
